// File: rtl/mips_main_control.sv
// Multicycle MIPS main control FSM. Sequences fetch/decode/execute/memory/writeback,
// drives the datapath enables and stretches memory states by MEM_WAIT cycles.
//
// state      | meaning
// -----------+------------------------------------------------------------
// FETCH      | read instruction at PC, PC+4 into PC and IR on last cycle
// DECODE     | latch opcode, precompute branch target in ALUOut
// MEM_ADDR   | compute rs + sign-ext imm for lw/sw
// MEM_READ   | data read at ALUOut
// MEM_WB     | write MDR to rt
// MEM_WRITE  | data write at ALUOut
// R_EXEC     | rs op rt, function from funct
// R_WB       | write ALUOut to rd
// BRANCH     | rs - rt, conditional PC load from ALUOut
// JUMP       | PC load from jump target
// ADDI_EXEC  | rs + sign-ext imm
// ADDI_WB    | write ALUOut to rt

module mips_main_control #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_nxt;
  logic [5:0] op_q, op_q_nxt;
  logic       wait_last;
  logic       mem_state;

  logic pc_write_raw, pc_write_cond_raw, mem_write_raw, ir_write_raw, reg_write_raw;

  assign wait_last = (wait_cnt == 4'(MEM_WAIT));
  assign mem_state = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= 4'd0;
      op_q     <= 6'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      op_q     <= op_q_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    op_q_nxt          = op_q;
    wait_nxt          = (mem_state && !wait_last) ? wait_cnt + 4'd1 : 4'd0;
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    mem_write_raw     = 1'b0;
    ir_write_raw      = 1'b0;
    reg_write_raw     = 1'b0;
    branch_ne         = 1'b0;
    iord              = 1'b0;
    mem_read          = 1'b0;
    mem_to_reg        = 1'b0;
    reg_dst           = 1'b0;
    alu_src_a         = 1'b0;
    alu_src_b         = 2'b00;
    pc_source         = 2'b00;
    alu_op            = 2'b00;
    illegal_op        = 1'b0;

    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (wait_last) begin
          ir_write_raw = 1'b1;
          pc_write_raw = 1'b1;
          state_nxt    = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        op_q_nxt  = opcode;
        case (opcode)
          OP_RTYPE:      state_nxt = S_R_EXEC;
          OP_LW, OP_SW:  state_nxt = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
          OP_J:          state_nxt = S_JUMP;
          OP_ADDI:       state_nxt = S_ADDI_EXEC;
          default: begin
            illegal_op = 1'b1;
            state_nxt  = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_nxt = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (wait_last) state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write_raw = 1'b1;
        iord          = 1'b1;
        if (wait_last) state_nxt = S_FETCH;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_nxt = S_R_WB;
      end
      S_R_WB: begin
        reg_write_raw = 1'b1;
        reg_dst       = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a         = 1'b1;
        alu_op            = 2'b01;
        pc_write_cond_raw = 1'b1;
        pc_source         = 2'b01;
        branch_ne         = (op_q == OP_BNE);
        state_nxt         = S_FETCH;
      end
      S_JUMP: begin
        pc_write_raw = 1'b1;
        pc_source    = 2'b10;
        state_nxt    = S_FETCH;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_nxt = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write_raw = 1'b1;
        state_nxt     = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Architectural writes are gated by reset itself so nothing glitches while rst_n is low.
  assign pc_write      = pc_write_raw & rst_n;
  assign pc_write_cond = pc_write_cond_raw & rst_n;
  assign mem_write     = mem_write_raw & rst_n;
  assign ir_write      = ir_write_raw & rst_n;
  assign reg_write     = reg_write_raw & rst_n;
  assign state_o       = state;

endmodule

// File: tb/tb_mips_main_control.sv
// Scoreboard bench for mips_main_control: three instances (MEM_WAIT = 0, 2, 3) run
// instruction streams; expected per-cycle control words come from an instruction-level model.

module tb_mips_main_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit done[3];

  localparam logic lo = 1'b0;
  localparam logic hi = 1'b1;

  // Control word: {state, pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
  //   ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op, illegal_op}
  function automatic logic [21:0] ev(input int st, input logic pcw, pcwc, bne, iord, mrd, mwr,
                                     irw, m2r, rdst, rw, asa, input logic [1:0] asb, psrc, aop,
                                     input logic ill);
    return {4'(st), pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, psrc, aop, ill};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int W = (g == 0) ? 0 : ((g == 1) ? 2 : 3);

    logic       rst_n;
    logic [5:0] opcode;
    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_source, alu_op;
    logic [3:0] state_o;
    logic [21:0] act;
    logic [21:0] exp_q[$];
    bit active;

    mips_main_control #(.MEM_WAIT(W)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
      .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
      .alu_op(alu_op), .illegal_op(illegal_op), .state_o(state_o)
    );

    assign act = {state_o, pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
                  ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
                  alu_op, illegal_op};

    function automatic int lat_of(input logic [5:0] op);
      case (op)
        6'h00:        return 4 + W;
        6'h23:        return 5 + 2 * W;
        6'h2B:        return 4 + 2 * W;
        6'h04, 6'h05: return 3 + W;
        6'h02:        return 3 + W;
        6'h08:        return 4 + W;
        default:      return 2 + W;
      endcase
    endfunction

    task automatic push_instr(input logic [5:0] op);
      for (int c = 0; c <= W; c++)
        exp_q.push_back(ev(0, c == W, lo, lo, lo, hi, lo, c == W, lo, lo, lo, lo, 2'b01, 2'b00, 2'b00, lo));
      exp_q.push_back(ev(1, lo, lo, lo, lo, lo, lo, lo, lo, lo, lo, lo, 2'b11, 2'b00, 2'b00, !is_legal(op)));
      case (op)
        6'h00: begin
          exp_q.push_back(ev(6, lo, lo, lo, lo, lo, lo, lo, lo, lo, lo, hi, 2'b00, 2'b00, 2'b10, lo));
          exp_q.push_back(ev(7, lo, lo, lo, lo, lo, lo, lo, lo, hi, hi, lo, 2'b00, 2'b00, 2'b00, lo));
        end
        6'h23, 6'h2B: begin
          exp_q.push_back(ev(2, lo, lo, lo, lo, lo, lo, lo, lo, lo, lo, hi, 2'b10, 2'b00, 2'b00, lo));
          for (int c = 0; c <= W; c++)
            if (op == 6'h23)
              exp_q.push_back(ev(3, lo, lo, lo, hi, hi, lo, lo, lo, lo, lo, lo, 2'b00, 2'b00, 2'b00, lo));
            else
              exp_q.push_back(ev(5, lo, lo, lo, hi, lo, hi, lo, lo, lo, lo, lo, 2'b00, 2'b00, 2'b00, lo));
          if (op == 6'h23)
            exp_q.push_back(ev(4, lo, lo, lo, lo, lo, lo, lo, hi, lo, hi, lo, 2'b00, 2'b00, 2'b00, lo));
        end
        6'h04, 6'h05:
          exp_q.push_back(ev(8, lo, hi, op == 6'h05, lo, lo, lo, lo, lo, lo, lo, hi, 2'b00, 2'b01, 2'b01, lo));
        6'h02:
          exp_q.push_back(ev(9, hi, lo, lo, lo, lo, lo, lo, lo, lo, lo, lo, 2'b00, 2'b10, 2'b00, lo));
        6'h08: begin
          exp_q.push_back(ev(10, lo, lo, lo, lo, lo, lo, lo, lo, lo, lo, hi, 2'b10, 2'b00, 2'b00, lo));
          exp_q.push_back(ev(11, lo, lo, lo, lo, lo, lo, lo, lo, lo, hi, lo, 2'b00, 2'b00, 2'b00, lo));
        end
        default: ;
      endcase
    endtask

    // Stimulus: directed prefix per instance, then random opcodes with occasional aborts.
    initial begin
      logic [5:0] pre[$];
      logic [5:0] legal[7] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B};
      logic [5:0] op;
      int lat, abort_at;
      if (W == 0) pre = '{6'h00, 6'h2B, 6'h05, 6'h04, 6'h3F};
      else if (W == 2) pre = '{6'h23};
      else pre = '{6'h23, 6'h23};
      opcode = 6'h00;
      rst_n  = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int n = 0; n < 45; n++) begin
        if (n < pre.size()) op = pre[n];
        else if ($urandom_range(0, 7) == 0) begin
          op = 6'($urandom);
          while (is_legal(op)) op = 6'($urandom);
        end else op = legal[$urandom_range(0, 6)];
        lat = lat_of(op);
        abort_at = 0;
        if (W == 3 && n == 0) abort_at = W + 4;
        else if (n >= pre.size() && $urandom_range(0, 15) == 0) abort_at = $urandom_range(1, lat - 1);
        opcode = op;
        push_instr(op);
        active = 1'b1;
        for (int c = 1; c <= lat; c++) begin
          @(posedge clk);
          #1;
          if (c == W + 2) opcode = (op == 6'h23) ? 6'h2B : 6'($urandom);
          if (c == abort_at) begin
            #1 rst_n = 1'b0;
            exp_q.delete();
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            break;
          end
        end
      end
      active = 1'b0;
      done[g] = 1'b1;
    end

    // Monitor: one control word per cycle while out of reset; reset view while held.
    always @(negedge clk) begin
      if (!rst_n) begin
        checks++;
        if (state_o !== 4'd0 || {pc_write, pc_write_cond, ir_write, reg_write, mem_write} !== 5'b0) begin
          failures++;
          $display("FAIL reset_hold w=%0d state=%0d strobes=%b required state=0 strobes=00000",
                   W, state_o, {pc_write, pc_write_cond, ir_write, reg_write, mem_write});
        end
      end else if (active) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL underflow w=%0d actual=%h required=<no word queued>", W, act);
        end else begin
          logic [21:0] e;
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL ctl_word w=%0d t=%0t actual=%h required=%h", W, $time, act, e);
          end
        end
      end
    end

    always @(negedge rst_n) begin
      #1;
      checks++;
      if (state_o !== 4'd0 || {pc_write, pc_write_cond, ir_write, reg_write, mem_write} !== 5'b0) begin
        failures++;
        $display("FAIL reset_async w=%0d state=%0d strobes=%b required state=0 strobes=00000",
                 W, state_o, {pc_write, pc_write_cond, ir_write, reg_write, mem_write});
      end
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(done[0] && done[1] && done[2]) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    if (!(done[0] && done[1] && done[2])) begin
      checks++;
      failures++;
      $display("FAIL timeout done=%b%b%b required=111", done[0], done[1], done[2]);
    end
    #20;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
